td4_core: RTL
=============

# td4_core

Single-cycle 4-bit TD4 execution core that sits directly downstream of the program ROM. It drives the 4-bit ROM address from its program counter and consumes the combinational 8-bit instruction word returned. It executes one instruction per enabled clock and updates registers A/B, the carry flag, the output port and the PC. External I/O is a 4-bit input port and a registered 4-bit output port.

## Interface
- No parameters. Widths are fixed by the ISA: 4-bit data, 4-bit address, 8-bit instruction.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; state advances only on edges where ce=1.
- rom_addr  out  4  current PC; fed to the ROM address.
- rom_data  in  8  instruction at rom_addr. [7:4] is the opcode, [3:0] is the immediate Im.
- in_port  in  4  external input switches; sampled by IN instructions.
- out_port  out  4  registered output LEDs.
- carry  out  1  carry flag register.
- halted  out  1  halt indicator; see Configuration.

## Operation
- State: PC[3:0], A[3:0], B[3:0], C (carry), OUT[3:0], plus the halt flag when compiled in.
- rom_addr = PC, driven combinationally from the register.
- Opcode decode on rom_data[7:4]. All results commit on the same edge.
  - 0000 ADD A,Im: {C,A} <= A+Im, 5-bit sum.
  - 0101 ADD B,Im: {C,B} <= B+Im.
  - 0011 MOV A,Im: A <= Im.
  - 0111 MOV B,Im: B <= Im.
  - 0001 MOV A,B: A <= B.
  - 0100 MOV B,A: B <= A.
  - 0010 IN A: A <= in_port.
  - 0110 IN B: B <= in_port.
  - 1001 OUT B: OUT <= B.
  - 1011 OUT Im: OUT <= Im.
  - 1111 JMP Im: PC <= Im.
  - 1110 JNC Im: PC <= Im if C==0, else PC+1.
- Carry rule: only ADD sets C to the sum bit 4. Every other instruction, including JNC itself and undefined opcodes, writes C <= 0.
- JNC tests the C value produced by the previous instruction.
- Undefined opcodes (1000, 1010, 1100, 1101): no register or OUT write, C <= 0, PC <= PC+1.
- Non-jump instructions: PC <= PC+1, mod 16. PC 15 wraps to 0.
- Arithmetic is unsigned mod 16 with carry-out; there is no carry-in.

## Timing
- Reset (async assert, sync-safe release): PC=0, A=0, B=0, C=0, OUT=0, halted=0.
- Reset asserted mid-program forces the reset values immediately, independent of clk and ce.
- Latency: the instruction at PC takes effect on the next enabled rising edge. out_port and carry change on that edge.
- rom_addr updates on the same edge, so the next instruction is visible one cycle later.
- ce=0 holds all state, including halted; in_port is ignored.
- in_port is sampled only on the edge that executes IN. It is assumed stable, with no synchronizer inside.

## Configuration
- Macro TD4_HALT_DETECT_EN.
- Defined:
  - An executed JMP, or a taken JNC, whose target equals the current PC sets halted=1 on that edge.
  - While halted=1, all state is frozen. rom_addr and out_port are held.
  - Only rst_n clears halted.
- Undefined:
  - halted is tied 0.
  - A jump-to-self simply re-executes every cycle. Architecturally visible state is identical except C, which is cleared on each re-execution.

## Test plan
- Reset then release, rom_data=8'hB5 (OUT 5) -> rom_addr=0 during reset; out_port=5 and rom_addr=1 after the first edge.
- Sequence 8'h3E (MOV A,14), then 8'h01 twice (ADD A,1) -> A=15 with C=0, then A=0 with C=1. Next 8'hE7 (JNC 7) -> not taken, rom_addr increments by 1 and C=0.
- Sequence MOV A,3; ADD A,1; JNC 9 -> taken, rom_addr=9. Then 8'h40 (MOV B,A), 8'h90 (OUT B) -> out_port=4.
- in_port=4'hA, execute 8'h60 (IN B) then 8'h90 -> out_port=A and C=0. Hold ce=0 for 3 cycles in between -> no state change.
- PC=15 executing ADD A,0 -> rom_addr wraps to 0. Assert rst_n=0 asynchronously mid-cycle -> all outputs return to 0 before the next edge.
- With TD4_HALT_DETECT_EN: at PC=15 execute 8'hFF -> halted=1 after one edge, and rom_addr stays 15 for 10 further cycles. Without the macro -> halted stays 0.

Source files
------------

// File: rtl/td4_core.sv
// TD4 4-bit single-cycle execution core: fetches from an external ROM at PC and commits one instruction per enabled edge.
// Optional jump-to-self halt detection is compiled in with `define TD4_HALT_DETECT_EN.
module td4_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry,
  output logic       halted
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       c_q, c_d;
  logic       jump_taken;
  logic       advance;
  logic [3:0] opcode, imm;
  logic [4:0] sum_a, sum_b;

  assign opcode = rom_data[7:4];
  assign imm    = rom_data[3:0];
  assign sum_a  = {1'b0, a_q} + {1'b0, imm};
  assign sum_b  = {1'b0, b_q} + {1'b0, imm};

  // Carry defaults to 0: only the two ADDs produce a carry-out.
  always_comb begin
    pc_d       = pc_q + 4'd1;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    c_d        = 1'b0;
    jump_taken = 1'b0;
    case (opcode)
      OP_ADD_A:  {c_d, a_d} = sum_a;
      OP_ADD_B:  {c_d, b_d} = sum_b;
      OP_MOV_A:  a_d = imm;
      OP_MOV_B:  b_d = imm;
      OP_MOV_AB: a_d = b_q;
      OP_MOV_BA: b_d = a_q;
      OP_IN_A:   a_d = in_port;
      OP_IN_B:   b_d = in_port;
      OP_OUT_B:  out_d = b_q;
      OP_OUT_I:  out_d = imm;
      OP_JMP: begin
        pc_d       = imm;
        jump_taken = 1'b1;
      end
      OP_JNC: begin
        if (!c_q) begin
          pc_d       = imm;
          jump_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef TD4_HALT_DETECT_EN
  logic halt_q, halt_d;

  // A taken jump back onto the current PC can never make progress, so freeze.
  always_comb begin
    halt_d = halt_q | (jump_taken && (imm == pc_q));
  end

  assign advance = ce & ~halt_q;
  assign halted  = halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (advance) begin
      halt_q <= halt_d;
    end
  end
`else
  logic unused_jump;

  assign unused_jump = jump_taken;
  assign advance     = ce;
  assign halted      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= 4'd0;
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      out_q <= 4'd0;
      c_q   <= 1'b0;
    end else if (advance) begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  assign rom_addr = pc_q;
  assign out_port = out_q;
  assign carry    = c_q;

endmodule
